mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, the address width.
REQ-002 SHALL have parameter DW, default 16, the data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum wait in cycles for mem_done before error.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_req  input  1  fetch stage requests an instruction read.
REQ-007 if_addr  input  AW  fetch address (PC).
REQ-008 dm_rd  input  1  MEM stage load request.
REQ-009 dm_wr  input  1  MEM stage store request.
REQ-010 dm_addr  input  AW  data address.
REQ-011 dm_wdata  input  DW  store data.
REQ-012 mem_rd  output  1  one-cycle read command to unified memory.
REQ-013 mem_wr  output  1  one-cycle write command to unified memory.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wdata  output  DW  memory write data.
REQ-016 mem_done  input  1  one-cycle completion pulse from memory; mem_rdata valid the same cycle.
REQ-017 mem_rdata  input  DW  memory read data.
REQ-018 if_rdata  output  DW  registered last fetched instruction.
REQ-019 dm_rdata  output  DW  registered last loaded data.
REQ-020 if_stall  output  1  fetch must hold (feeds PC and IF/ID write-enable).
REQ-021 dm_stall  output  1  MEM stage and all older stages must hold.
REQ-022 err  output  1  sticky error flag.

Function
REQ-023 FSM states SHALL be IDLE, D_WAIT, I_WAIT.
REQ-024 In IDLE, a data request SHALL win over if_req when both are present, because the MEM-stage instruction is older.
REQ-025 In IDLE with a valid request, the grant cycle SHALL drive mem_rd or mem_wr high for exactly that cycle, together with the selected address and data (Mealy outputs); next state is D_WAIT or I_WAIT.
REQ-026 On the grant cycle, address, write data and the request type SHALL be captured into registers, and mem_addr/mem_wdata SHALL come from those registers for the whole WAIT state.
REQ-027 In a WAIT state, mem_rd and mem_wr SHALL be 0; on mem_done the FSM SHALL return to IDLE, and mem_rdata SHALL be loaded into if_rdata (I_WAIT) or dm_rdata (D_WAIT, reads only).
REQ-028 if_stall SHALL be if_req AND NOT (state==I_WAIT AND mem_done).
REQ-029 dm_stall SHALL be (dm_rd OR dm_wr) AND NOT (state==D_WAIT AND mem_done).
REQ-030 Minimum access SHALL take grant cycle plus one done cycle; back-to-back grants SHALL NOT occur, so IDLE is always visited for one cycle.
REQ-031 An outstanding transaction SHALL NOT be aborted: deassertion of the request (for example, a flush on a taken branch) SHALL NOT change state, and the result is written to the rdata register regardless.
REQ-032 If dm_rd and dm_wr are both high in IDLE, err SHALL be set, no command SHALL be issued, and if_req SHALL NOT be granted that cycle.
REQ-033 A wait counter SHALL clear on grant and increment each WAIT cycle; if it reaches TIMEOUT without mem_done, err SHALL be set and the FSM SHALL return to IDLE.
REQ-034 mem_done while in IDLE SHALL be ignored and SHALL set err.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 Reset SHALL force state IDLE, wait counter 0, err 0, if_rdata 0 and dm_rdata 0; mem_rd and mem_wr SHALL be 0 while rst is high.
REQ-037 Reset asserted mid-transaction SHALL drop the transaction, and a later mem_done from that transaction SHALL be treated per REQ-034.

Structure
REQ-038 The state enumeration and the default TIMEOUT SHALL live in the shared pipeline package.
REQ-039 The wait counter and timeout compare SHALL be one sub-module, mem_arb_wdog; the rest is flat.

Verification
REQ-040 Memory model latency 3; if_req only, if_addr=0x0010, rdata=0xA5A5 -> mem_rd pulse at grant, if_stall high 3 cycles then low on done, if_rdata=0xA5A5.
REQ-041 if_req and dm_rd in the same cycle, dm_addr=0x0200 -> data is granted first (mem_addr=0x0200), if_stall held; fetch is granted in the cycle after IDLE.
REQ-042 dm_wr, dm_addr=0x0040, dm_wdata=0x1234 -> one mem_wr pulse with mem_wdata=0x1234; dm_rdata unchanged.
REQ-043 Fetch granted, if_req dropped one cycle later (flush) -> FSM stays in I_WAIT until mem_done, if_rdata updates, if_stall low.
REQ-044 Memory never returns mem_done -> err=1 after 15 WAIT cycles, FSM in IDLE; dm_rd and dm_wr both high -> err=1 with no command issued.
REQ-045 rst pulsed during D_WAIT, then a stray mem_done -> all outputs 0 after reset, then err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and default sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDWait = 2'd1,
    StIWait = 2'd2
  } arb_state_e;

  localparam int unsigned DefAw      = 16;
  localparam int unsigned DefDw      = 16;
  localparam int unsigned DefTimeout = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + MEM stage), the arbiter and the unified memory.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] dm_rdata;
  logic          if_stall;
  logic          dm_stall;
  logic          err;

  // Environment side: pipeline requesters and the memory itself.
  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata, if_stall, dm_stall, err
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata, if_stall, dm_stall, err
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Wait-cycle watchdog: cleared on grant, counts WAIT cycles, flags when TIMEOUT is reached.
module mem_arb_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the WAIT cycle whose increment reaches TIMEOUT.
  assign expired_o = en_i && !clr_i && (cnt_d == CntW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one unified memory port, one access at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;

  logic          rd_cmd, wr_cmd, grant, expired;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] wdata_out;
  logic          dm_req;

  assign dm_req = bus.dm_rd | bus.dm_wr;

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (grant),
    .en_i     (state_q != StIdle),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    rd_cmd     = 1'b0;
    wr_cmd     = 1'b0;
    grant      = 1'b0;
    addr_out   = addr_q;
    wdata_out  = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.mem_done) err_d = 1'b1;
        // Data side wins: the MEM-stage instruction is older than the fetch.
        if (bus.dm_rd && bus.dm_wr) begin
          err_d = 1'b1;
        end else if (dm_req) begin
          grant     = 1'b1;
          rd_cmd    = bus.dm_rd;
          wr_cmd    = bus.dm_wr;
          addr_out  = bus.dm_addr;
          wdata_out = bus.dm_wdata;
          state_d   = StDWait;
        end else if (bus.if_req) begin
          grant     = 1'b1;
          rd_cmd    = 1'b1;
          addr_out  = bus.if_addr;
          wdata_out = '0;
          state_d   = StIWait;
        end
        if (grant) begin
          addr_d  = addr_out;
          wdata_d = wdata_out;
          wr_d    = wr_cmd;
        end
      end
      StDWait: begin
        if (bus.mem_done) begin
          state_d = StIdle;
          if (!wr_q) dm_rdata_d = bus.mem_rdata;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StIWait: begin
        if (bus.mem_done) begin
          state_d    = StIdle;
          if_rdata_d = bus.mem_rdata;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_rd    = rd_cmd & ~rst;
  assign bus.mem_wr    = wr_cmd & ~rst;
  assign bus.mem_addr  = addr_out;
  assign bus.mem_wdata = wdata_out;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~((state_q == StIWait) & bus.mem_done);
  assign bus.dm_stall  = dm_req & ~((state_q == StDWait) & bus.mem_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-3 memory model, transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned MemLat  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(
    .AW     (16),
    .DW     (16),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers every command MemLat cycles after the grant, unless told to stay silent.
  int          lat         = 0;
  bit          respond     = 1'b1;
  logic [15:0] rdata_next  = '0;
  logic        mem_done_t  = 1'b0;
  logic [15:0] mem_rdata_t = '0;

  assign bus.mem_done  = mem_done_t;
  assign bus.mem_rdata = mem_rdata_t;

  always @(negedge clk) begin
    if (bus.mem_rd || bus.mem_wr) lat = MemLat;
  end

  always @(posedge clk) begin
    #2;
    mem_done_t = 1'b0;
    if (lat > 0) begin
      lat--;
      if (lat == 0 && respond) begin
        mem_done_t  = 1'b1;
        mem_rdata_t = rdata_next;
      end
    end
  end

  // Reference model: one outstanding access (kind 0 none, 1 data, 2 fetch) plus its age.
  int          m_kind  = 0;
  int          m_age   = 0;
  bit          m_wr    = 1'b0;
  bit          m_err   = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_if    = '0;
  logic [15:0] m_dm    = '0;

  int          g_kind;
  logic        e_rd, e_wr;
  logic [15:0] e_addr, e_wdata;
  logic        done_here;

  always @(negedge clk) begin
    if (rst) begin
      m_kind = 0;
      m_age  = 0;
      m_err  = 1'b0;
      m_if   = '0;
      m_dm   = '0;
      m_addr = '0;
      m_wdata = '0;
    end
    g_kind  = 0;
    e_rd    = 1'b0;
    e_wr    = 1'b0;
    e_addr  = m_addr;
    e_wdata = m_wdata;
    if (!rst && m_kind == 0 && !(bus.dm_rd && bus.dm_wr)) begin
      if (bus.dm_rd || bus.dm_wr) begin
        g_kind  = 1;
        e_rd    = bus.dm_rd;
        e_wr    = bus.dm_wr;
        e_addr  = bus.dm_addr;
        e_wdata = bus.dm_wdata;
      end else if (bus.if_req) begin
        g_kind  = 2;
        e_rd    = 1'b1;
        e_addr  = bus.if_addr;
        e_wdata = '0;
      end
    end
    done_here = (m_kind != 0) && bus.mem_done;

    check("cmp_mem_rd", {31'b0, bus.mem_rd}, {31'b0, e_rd});
    check("cmp_mem_wr", {31'b0, bus.mem_wr}, {31'b0, e_wr});
    check("cmp_if_stall", {31'b0, bus.if_stall},
          {31'b0, bus.if_req && !(done_here && m_kind == 2)});
    check("cmp_dm_stall", {31'b0, bus.dm_stall},
          {31'b0, (bus.dm_rd || bus.dm_wr) && !(done_here && m_kind == 1)});
    check("cmp_err", {31'b0, bus.err}, {31'b0, m_err});
    check("cmp_if_rdata", {16'b0, bus.if_rdata}, {16'b0, m_if});
    check("cmp_dm_rdata", {16'b0, bus.dm_rdata}, {16'b0, m_dm});
    if (g_kind != 0 || m_kind != 0) begin
      check("cmp_mem_addr", {16'b0, bus.mem_addr}, {16'b0, e_addr});
      check("cmp_mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, e_wdata});
    end

    if (!rst) begin
      if (m_kind == 0) begin
        if (bus.mem_done) m_err = 1'b1;
        if (bus.dm_rd && bus.dm_wr) m_err = 1'b1;
        if (g_kind != 0) begin
          m_kind  = g_kind;
          m_age   = 0;
          m_wr    = e_wr;
          m_addr  = e_addr;
          m_wdata = e_wdata;
        end
      end else if (bus.mem_done) begin
        if (m_kind == 2) m_if = bus.mem_rdata;
        else if (!m_wr) m_dm = bus.mem_rdata;
        m_kind = 0;
      end else begin
        m_age++;
        if (m_age == TIMEOUT) begin
          m_err  = 1'b1;
          m_kind = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_rd    = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;

    repeat (2) cyc();
    @(negedge clk);
    check("rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_if_rdata", {16'b0, bus.if_rdata}, 32'd0);
    check("rst_dm_rdata", {16'b0, bus.dm_rdata}, 32'd0);
    cyc(); rst = 1'b0;

    // Plain fetch.
    cyc(); rdata_next = 16'hA5A5; bus.if_addr = 16'h0010; bus.if_req = 1'b1;
    @(negedge clk);
    check("t1_grant_rd", {31'b0, bus.mem_rd}, 32'd1);
    check("t1_grant_addr", {16'b0, bus.mem_addr}, 32'h0010);
    check("t1_stall_c0", {31'b0, bus.if_stall}, 32'd1);
    cyc(); @(negedge clk);
    check("t1_stall_c1", {31'b0, bus.if_stall}, 32'd1);
    check("t1_rd_c1", {31'b0, bus.mem_rd}, 32'd0);
    cyc(); @(negedge clk);
    check("t1_stall_c2", {31'b0, bus.if_stall}, 32'd1);
    cyc(); @(negedge clk);
    check("t1_stall_done", {31'b0, bus.if_stall}, 32'd0);
    cyc(); bus.if_req = 1'b0; @(negedge clk);
    check("t1_if_rdata", {16'b0, bus.if_rdata}, 32'hA5A5);

    // Simultaneous fetch and load: load first, fetch in the following IDLE cycle.
    cyc(); bus.if_req = 1'b1; bus.if_addr = 16'h0020; bus.dm_rd = 1'b1;
    bus.dm_addr = 16'h0200; rdata_next = 16'h5555;
    @(negedge clk);
    check("t2_grant_addr", {16'b0, bus.mem_addr}, 32'h0200);
    check("t2_if_stall", {31'b0, bus.if_stall}, 32'd1);
    cyc(); cyc(); cyc(); @(negedge clk);
    check("t2_dm_stall_done", {31'b0, bus.dm_stall}, 32'd0);
    check("t2_if_stall_held", {31'b0, bus.if_stall}, 32'd1);
    cyc(); bus.dm_rd = 1'b0; rdata_next = 16'h6666; @(negedge clk);
    check("t2_fetch_rd", {31'b0, bus.mem_rd}, 32'd1);
    check("t2_fetch_addr", {16'b0, bus.mem_addr}, 32'h0020);
    cyc(); cyc(); cyc();
    cyc(); bus.if_req = 1'b0; @(negedge clk);
    check("t2_dm_rdata", {16'b0, bus.dm_rdata}, 32'h5555);
    check("t2_if_rdata", {16'b0, bus.if_rdata}, 32'h6666);

    // Store.
    cyc(); bus.dm_wr = 1'b1; bus.dm_addr = 16'h0040; bus.dm_wdata = 16'h1234;
    rdata_next = 16'hDEAD;
    @(negedge clk);
    check("t3_wr", {31'b0, bus.mem_wr}, 32'd1);
    check("t3_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("t3_wdata", {16'b0, bus.mem_wdata}, 32'h1234);
    cyc(); @(negedge clk);
    check("t3_wr_pulse", {31'b0, bus.mem_wr}, 32'd0);
    check("t3_wdata_held", {16'b0, bus.mem_wdata}, 32'h1234);
    cyc(); cyc();
    cyc(); bus.dm_wr = 1'b0; @(negedge clk);
    check("t3_dm_rdata_kept", {16'b0, bus.dm_rdata}, 32'h5555);

    // Fetch flushed one cycle after grant still completes.
    cyc(); bus.if_req = 1'b1; bus.if_addr = 16'h0030; rdata_next = 16'h0BAD;
    cyc(); bus.if_req = 1'b0; @(negedge clk);
    check("t4_no_regrant", {31'b0, bus.mem_rd}, 32'd0);
    cyc(); @(negedge clk);
    check("t4_addr_held", {16'b0, bus.mem_addr}, 32'h0030);
    cyc();
    cyc(); @(negedge clk);
    check("t4_if_rdata", {16'b0, bus.if_rdata}, 32'h0BAD);

    // Memory never answers: timeout after 15 WAIT cycles.
    cyc(); respond = 1'b0; bus.dm_rd = 1'b1; bus.dm_addr = 16'h0300;
    cyc(); bus.dm_rd = 1'b0;
    repeat (13) cyc();
    cyc(); @(negedge clk);
    check("t5_err_before", {31'b0, bus.err}, 32'd0);
    cyc(); respond = 1'b1; bus.if_req = 1'b1; bus.if_addr = 16'h0050; rdata_next = 16'h1111;
    @(negedge clk);
    check("t5_err_after", {31'b0, bus.err}, 32'd1);
    check("t5_idle_grant", {31'b0, bus.mem_rd}, 32'd1);
    cyc(); bus.if_req = 1'b0;
    cyc(); cyc();
    cyc(); @(negedge clk);
    check("t5_if_rdata", {16'b0, bus.if_rdata}, 32'h1111);

    // Conflicting load and store in IDLE.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; @(negedge clk);
    check("t6_err_cleared", {31'b0, bus.err}, 32'd0);
    cyc(); bus.dm_rd = 1'b1; bus.dm_wr = 1'b1; bus.if_req = 1'b1; @(negedge clk);
    check("t6_no_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("t6_no_wr", {31'b0, bus.mem_wr}, 32'd0);
    cyc(); bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.if_req = 1'b0; @(negedge clk);
    check("t6_err", {31'b0, bus.err}, 32'd1);

    // Reset during D_WAIT, then the dropped transaction's mem_done arrives in IDLE.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); bus.dm_rd = 1'b1; bus.dm_addr = 16'h0400; rdata_next = 16'h7777; @(negedge clk);
    check("t7_grant", {31'b0, bus.mem_rd}, 32'd1);
    cyc(); rst = 1'b1; bus.dm_rd = 1'b0; @(negedge clk);
    check("t7_rst_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("t7_rst_err", {31'b0, bus.err}, 32'd0);
    check("t7_rst_dm_rdata", {16'b0, bus.dm_rdata}, 32'd0);
    check("t7_rst_dm_stall", {31'b0, bus.dm_stall}, 32'd0);
    cyc(); rst = 1'b0;
    cyc(); @(negedge clk);
    check("t7_err_pre", {31'b0, bus.err}, 32'd0);
    cyc(); @(negedge clk);
    check("t7_err_stray", {31'b0, bus.err}, 32'd1);
    check("t7_dm_rdata", {16'b0, bus.dm_rdata}, 32'd0);

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish in time");
    $fatal(1);
  end

endmodule
